// File: rtl/opnd_demux.sv
// Write-side operand demux: steers one data word per write into one of four
// holding registers, either by an external one-hot select or by a rotating
// internal pointer. Tracks per-register loaded flags and a sticky error flag.
module opnd_demux #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic [3:0]       sel,
    input  logic             auto,
    input  logic             clr,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [3:0]       loaded,
    output logic [3:0]       ptr,
    output logic             full,
    output logic             err
);

    logic [3:0][WIDTH-1:0] regs_q, regs_d;
    logic [3:0]            loaded_q, loaded_d;
    logic [3:0]            ptr_q, ptr_d;
    logic                  err_q, err_d;

    logic                  sel_onehot;
    logic [3:0]            wr_mask;

    // Decode which register (if any) this edge writes, and whether sel is illegal.
    always_comb begin
        sel_onehot = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
        wr_mask    = 4'b0000;
        if (wr_en && !clr) begin
            if (auto) begin
                wr_mask = ptr_q;
            end else if (sel_onehot) begin
                wr_mask = sel;
            end
        end
    end

    // Next-state: clr beats write; bad manual select only raises err.
    always_comb begin
        regs_d   = regs_q;
        loaded_d = loaded_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        if (clr) begin
            regs_d   = '0;
            loaded_d = 4'b0000;
            ptr_d    = 4'b0001;
            err_d    = 1'b0;
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_mask[k]) begin
                    regs_d[k] = din;
                end
            end
            loaded_d = loaded_q | wr_mask;
            if (auto) begin
                ptr_d = {ptr_q[2:0], ptr_q[3]};
            end else if (!sel_onehot) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '0;
            loaded_q <= 4'b0000;
            ptr_q    <= 4'b0001;
            err_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            loaded_q <= loaded_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
        end
    end

    // Outputs: all registered except full, which is decoded from loaded.
    always_comb begin
        O0     = regs_q[0];
        O1     = regs_q[1];
        O2     = regs_q[2];
        O3     = regs_q[3];
        loaded = loaded_q;
        ptr    = ptr_q;
        err    = err_q;
        full   = (loaded_q == 4'b1111);
    end

endmodule

// File: tb/tb_opnd_demux.sv
// Self-checking bench for opnd_demux: directed vectors, a behavioural model
// compared every cycle, and literal expectations after key steps.
module tb_opnd_demux;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        wr_en;
    logic [3:0]  sel;
    logic        auto;
    logic        clr;
    logic [15:0] O0, O1, O2, O3;
    logic [3:0]  loaded;
    logic [3:0]  ptr;
    logic        full;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    opnd_demux #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .wr_en  (wr_en),
        .sel    (sel),
        .auto   (auto),
        .clr    (clr),
        .O0     (O0),
        .O1     (O1),
        .O2     (O2),
        .O3     (O3),
        .loaded (loaded),
        .ptr    (ptr),
        .full   (full),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: register array indexed by an integer pointer.
    logic [15:0] m_o [4];
    logic [3:0]  m_loaded;
    int          m_ptr;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_o[k] <= 16'h0;
            m_loaded <= 4'h0;
            m_ptr    <= 0;
            m_err    <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < 4; k++) m_o[k] <= 16'h0;
            m_loaded <= 4'h0;
            m_ptr    <= 0;
            m_err    <= 1'b0;
        end else if (wr_en) begin
            if (auto) begin
                m_o[m_ptr]      <= din;
                m_loaded[m_ptr] <= 1'b1;
                m_ptr           <= (m_ptr + 1) % 4;
            end else if ($countones(sel) == 1) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel[k]) begin
                        m_o[k]      <= din;
                        m_loaded[k] <= 1'b1;
                    end
                end
            end else begin
                m_err <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] exp_ptr;
            exp_ptr = 4'b0001 << m_ptr;
            check("model O0", {16'h0, O0}, {16'h0, m_o[0]});
            check("model O1", {16'h0, O1}, {16'h0, m_o[1]});
            check("model O2", {16'h0, O2}, {16'h0, m_o[2]});
            check("model O3", {16'h0, O3}, {16'h0, m_o[3]});
            check("model loaded", {28'h0, loaded}, {28'h0, m_loaded});
            check("model ptr", {28'h0, ptr}, {28'h0, exp_ptr});
            check("model err", {31'h0, err}, {31'h0, m_err});
            check("model full", {31'h0, full}, {31'h0, (m_loaded == 4'hF)});
        end
    end

    // Apply one set of inputs for the next rising edge; return 2 time units after it.
    task automatic cyc(input logic w, input logic [3:0] s, input logic a, input logic c,
                       input logic [15:0] d);
        wr_en = w;
        sel   = s;
        auto  = a;
        clr   = c;
        din   = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b1;
        sel   = 4'b0001;
        auto  = 1'b0;
        clr   = 1'b0;
        din   = 16'hFFFF;
        @(posedge clk);
        #2;
        chk_en = 1'b1;

        // Reset held with an active write request.
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 16'hFFFF);
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 16'hFFFF);
        check("rst O0", {16'h0, O0}, 32'h0);
        check("rst loaded", {28'h0, loaded}, 32'h0);
        check("rst ptr", {28'h0, ptr}, 32'h1);
        check("rst err", {31'h0, err}, 32'h0);
        check("rst full", {31'h0, full}, 32'h0);
        rst_n = 1'b1;

        // Manual fill in mixed order.
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 16'h1111);
        check("fill1 O0", {16'h0, O0}, 32'h1111);
        check("fill1 loaded", {28'h0, loaded}, 32'h1);
        cyc(1'b1, 4'b0100, 1'b0, 1'b0, 16'h3333);
        check("fill2 loaded", {28'h0, loaded}, 32'h5);
        cyc(1'b1, 4'b0010, 1'b0, 1'b0, 16'h2222);
        check("fill3 loaded", {28'h0, loaded}, 32'h7);
        check("fill3 full", {31'h0, full}, 32'h0);
        cyc(1'b1, 4'b1000, 1'b0, 1'b0, 16'h4444);
        check("fill4 loaded", {28'h0, loaded}, 32'hF);
        check("fill4 full", {31'h0, full}, 32'h1);
        check("fill4 O1", {16'h0, O1}, 32'h2222);
        check("fill4 O2", {16'h0, O2}, 32'h3333);
        check("fill4 O3", {16'h0, O3}, 32'h4444);
        check("fill4 ptr", {28'h0, ptr}, 32'h1);

        // Illegal selects are dropped and set the sticky error.
        cyc(1'b1, 4'b0011, 1'b0, 1'b0, 16'hABCD);
        check("bad1 err", {31'h0, err}, 32'h1);
        check("bad1 O0", {16'h0, O0}, 32'h1111);
        check("bad1 O1", {16'h0, O1}, 32'h2222);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 16'hABCD);
        check("bad2 err", {31'h0, err}, 32'h1);
        check("bad2 loaded", {28'h0, loaded}, 32'hF);
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 16'h5555);
        check("legal O0", {16'h0, O0}, 32'h5555);
        check("legal err", {31'h0, err}, 32'h1);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 16'h0);
        check("clr err", {31'h0, err}, 32'h0);
        check("clr loaded", {28'h0, loaded}, 32'h0);

        // Auto rotation, sel ignored, pointer wraps.
        cyc(1'b1, 4'b0110, 1'b1, 1'b0, 16'h0001);
        check("auto1 ptr", {28'h0, ptr}, 32'h2);
        cyc(1'b1, 4'b0110, 1'b1, 1'b0, 16'h0002);
        check("auto2 ptr", {28'h0, ptr}, 32'h4);
        cyc(1'b1, 4'b0110, 1'b1, 1'b0, 16'h0003);
        check("auto3 ptr", {28'h0, ptr}, 32'h8);
        cyc(1'b1, 4'b0110, 1'b1, 1'b0, 16'h0004);
        check("auto4 ptr", {28'h0, ptr}, 32'h1);
        check("auto4 full", {31'h0, full}, 32'h1);
        cyc(1'b1, 4'b0110, 1'b1, 1'b0, 16'h0005);
        check("auto5 ptr", {28'h0, ptr}, 32'h2);
        check("auto5 O0", {16'h0, O0}, 32'h5);
        check("auto5 O1", {16'h0, O1}, 32'h2);
        check("auto5 O2", {16'h0, O2}, 32'h3);
        check("auto5 O3", {16'h0, O3}, 32'h4);
        check("auto5 err", {31'h0, err}, 32'h0);

        // Idle cycle while toggling auto: nothing moves.
        cyc(1'b0, 4'b0001, 1'b0, 1'b0, 16'h9999);
        check("idle ptr", {28'h0, ptr}, 32'h2);
        check("idle O0", {16'h0, O0}, 32'h5);

        // clr beats a simultaneous write.
        cyc(1'b1, 4'b0001, 1'b0, 1'b1, 16'h7777);
        check("clrwr O0", {16'h0, O0}, 32'h0);
        check("clrwr loaded", {28'h0, loaded}, 32'h0);
        check("clrwr ptr", {28'h0, ptr}, 32'h1);
        check("clrwr full", {31'h0, full}, 32'h0);

        // Async reset mid-stream with ptr at 0100.
        cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0011);
        cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0022);
        check("pre-rst ptr", {28'h0, ptr}, 32'h4);
        check("pre-rst O1", {16'h0, O1}, 32'h22);
        #1;
        rst_n = 1'b0;
        #1;
        check("async O0", {16'h0, O0}, 32'h0);
        check("async O1", {16'h0, O1}, 32'h0);
        check("async ptr", {28'h0, ptr}, 32'h1);
        check("async loaded", {28'h0, loaded}, 32'h0);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h00AA);
        check("post-rst O0", {16'h0, O0}, 32'hAA);
        check("post-rst ptr", {28'h0, ptr}, 32'h2);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
